// File: rtl/line_fetch_engine.sv
// Line fetch engine: refills a cache line from external memory, or writes a victim line back.
// Optional build macro LINE_FETCH_STAT_EN adds saturating refill/write-back completion counters.
`timescale 1ns/1ps
module line_fetch_engine #(
    parameter int unsigned addr_width = 32,
    parameter int unsigned list_depth = 4,
    parameter int unsigned data_width = 32,
    parameter int unsigned list_width = 32,
    localparam int unsigned TW = $clog2(list_depth),
    localparam int unsigned IW = $clog2(list_width)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_req,
    input  logic [1:0]            fetch_cmd,
    input  logic [TW-1:0]         fetch_tag,
    input  logic [addr_width-1:0] fetch_addr,
    output logic                  fetch_gnt,
    output logic                  fetch_done,
    output logic                  ext_req,
    output logic                  ext_we,
    output logic [addr_width-1:0] ext_addr,
    output logic [data_width-1:0] ext_wdata,
    input  logic                  ext_gnt,
    input  logic [data_width-1:0] ext_rdata,
    input  logic                  ext_rdata_valid,
    output logic                  mem_wen,
    output logic [TW+IW-1:0]      mem_waddr,
    output logic [data_width-1:0] mem_wdata,
    output logic                  mem_ren,
    output logic [TW+IW-1:0]      mem_raddr,
    input  logic                  mem_rready,
    input  logic [data_width-1:0] mem_rdata,
    input  logic                  mem_rdata_valid,
    output logic [15:0]           stat_refill_cnt,
    output logic [15:0]           stat_wb_cnt
);

    localparam int unsigned Bytes = data_width / 8;
    localparam logic [IW-1:0] LastIdx = IW'(list_width - 1);

    typedef enum logic [2:0] {
        StIdle, StRfIssue, StRfDrain, StWbRd, StWbWait, StWbWr, StDone
    } state_e;

    state_e                  state_q;
    logic [TW-1:0]           tag_q;
    logic [addr_width-1:0]   addr_q;
    logic [IW-1:0]           issue_idx_q;
    logic [IW-1:0]           recv_idx_q;
    logic [data_width-1:0]   hold_q;
    logic                    rf_active;

    assign rf_active = (state_q == StRfIssue) || (state_q == StRfDrain);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            tag_q       <= '0;
            addr_q      <= '0;
            issue_idx_q <= '0;
            recv_idx_q  <= '0;
            hold_q      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (fetch_req) begin
                        tag_q       <= fetch_tag;
                        addr_q      <= fetch_addr;
                        issue_idx_q <= '0;
                        recv_idx_q  <= '0;
                        if (fetch_cmd[1])      state_q <= StDone;
                        else if (fetch_cmd[0]) state_q <= StRfIssue;
                        else                   state_q <= StWbRd;
                    end
                end
                StRfIssue: begin
                    if (ext_gnt) begin
                        issue_idx_q <= issue_idx_q + 1'b1;
                        if (issue_idx_q == LastIdx) state_q <= StRfDrain;
                    end
                end
                StRfDrain: ;
                StWbRd: begin
                    if (mem_rready) state_q <= StWbWait;
                end
                StWbWait: begin
                    if (mem_rdata_valid) begin
                        hold_q  <= mem_rdata;
                        state_q <= StWbWr;
                    end
                end
                StWbWr: begin
                    if (ext_gnt) begin
                        if (issue_idx_q == LastIdx) begin
                            state_q <= StDone;
                        end else begin
                            issue_idx_q <= issue_idx_q + 1'b1;
                            state_q     <= StWbRd;
                        end
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
            // Response side runs independently of issue; last response ends the refill.
            if (mem_wen) begin
                recv_idx_q <= recv_idx_q + 1'b1;
                if (recv_idx_q == LastIdx) state_q <= StDone;
            end
        end
    end

    assign fetch_gnt  = (state_q == StIdle);
    assign fetch_done = (state_q == StDone);
    assign ext_req    = (state_q == StRfIssue) || (state_q == StWbWr);
    assign ext_we     = (state_q == StWbWr);
    assign ext_addr   = addr_q + addr_width'(issue_idx_q) * addr_width'(Bytes);
    assign ext_wdata  = hold_q;
    assign mem_wen    = rf_active && ext_rdata_valid;
    assign mem_waddr  = {tag_q, recv_idx_q};
    assign mem_wdata  = mem_wen ? ext_rdata : '0;
    assign mem_ren    = (state_q == StWbRd);
    assign mem_raddr  = {tag_q, issue_idx_q};

`ifdef LINE_FETCH_STAT_EN
    logic [1:0]  cmd_q;
    logic [15:0] refill_cnt_q;
    logic [15:0] wb_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q        <= '0;
            refill_cnt_q <= '0;
            wb_cnt_q     <= '0;
        end else begin
            if (state_q == StIdle && fetch_req) cmd_q <= fetch_cmd;
            if (state_q == StDone) begin
                if (cmd_q == 2'b01 && refill_cnt_q != 16'hFFFF) refill_cnt_q <= refill_cnt_q + 1'b1;
                if (cmd_q == 2'b00 && wb_cnt_q != 16'hFFFF)     wb_cnt_q     <= wb_cnt_q + 1'b1;
            end
        end
    end

    assign stat_refill_cnt = refill_cnt_q;
    assign stat_wb_cnt     = wb_cnt_q;
`else
    assign stat_refill_cnt = '0;
    assign stat_wb_cnt     = '0;
`endif

endmodule

// File: doc/line_fetch_engine.md
# line_fetch_engine

Line fetch engine sitting directly downstream of the cache read/write controllers' fetch interface. It accepts one line command at a time. A command either refills a cache line from external memory into the line data memory, or writes a victim line back from line data memory to external memory. Completion is reported with a single-cycle `fetch_done`.

## Interface
- `addr_width`, 32, byte address width
- `list_depth`, 4, number of lines (tags)
- `data_width`, 32, word width in bits
- `list_width`, 32, words per line

Ports. `TW` = $clog2(list_depth), `IW` = $clog2(list_width).
- `clk` in 1: clock
- `rst_n` in 1: reset, asynchronous, active-low
- `fetch_req` in 1: command valid
- `fetch_cmd` in 2: 2'b01 refill; 2'b00 write-back; 2'b1x no-op
- `fetch_tag` in TW: target line slot
- `fetch_addr` in addr_width: line-aligned external byte address
- `fetch_gnt` out 1: command accepted
- `fetch_done` out 1: one-cycle completion pulse
- `ext_req` out 1: external word request
- `ext_we` out 1: 1 = write, 0 = read
- `ext_addr` out addr_width: external byte address
- `ext_wdata` out data_width: write data
- `ext_gnt` in 1: external request accepted
- `ext_rdata` in data_width: read response data
- `ext_rdata_valid` in 1: read response valid; in request order
- `mem_wen` out 1: line memory write
- `mem_waddr` out TW+IW: {tag, word index}
- `mem_wdata` out data_width: write data
- `mem_ren` out 1: line memory read request
- `mem_raddr` out TW+IW: {tag, word index}
- `mem_rready` in 1: read request accepted
- `mem_rdata` in data_width: read data
- `mem_rdata_valid` in 1: read data valid
- `stat_refill_cnt` out 16: refills completed
- `stat_wb_cnt` out 16: write-backs completed

## Operation
- States:
  - IDLE, RF_ISSUE, RF_DRAIN (refill)
  - WB_RD, WB_WAIT, WB_WR (write-back)
  - DONE
- Acceptance:
  - `fetch_gnt` = (state == IDLE), combinational.
  - Handshake is `fetch_req && fetch_gnt`.
  - On handshake, `fetch_tag`, `fetch_addr` and `fetch_cmd` are latched. Issue index and receive index clear to 0.
- Refill (cmd 01):
  - RF_ISSUE: `ext_req`=1, `ext_we`=0, `ext_addr` = addr_ff + issue_idx*(data_width/8). Each `ext_gnt` increments issue_idx.
  - Grant of word list_width-1 moves to RF_DRAIN; if all responses are already in, it moves directly to DONE.
  - In RF_ISSUE and RF_DRAIN, each `ext_rdata_valid` drives, same cycle, `mem_wen`=1, `mem_waddr`={tag_ff, recv_idx}, `mem_wdata`=`ext_rdata`, and increments recv_idx.
  - The write port has no backpressure; it always accepts.
  - Responses may overlap issue.
  - The last response (recv_idx == list_width-1) moves to DONE.
- Write-back (cmd 00):
  - WB_RD: `mem_ren`=1, `mem_raddr`={tag_ff, idx}. `mem_rready` moves to WB_WAIT.
  - WB_WAIT: `mem_rdata_valid` captures `mem_rdata` into the hold register and moves to WB_WR.
  - WB_WR: `ext_req`=1, `ext_we`=1, `ext_addr` = addr_ff + idx*(data_width/8), `ext_wdata`=hold.
  - On `ext_gnt`: if idx == list_width-1 go to DONE; else idx++ and go to WB_RD.
  - Writes are posted; there is no write response.
- No-op (cmd 1x): IDLE goes to DONE with no bus or memory activity.
- DONE: `fetch_done`=1 for exactly one cycle, then IDLE.
- Address arithmetic is addr_width modulo; wrap is not checked. Indices are IW bits and wrap to 0 only via a new command.
- Stray input:
  - `ext_rdata_valid` outside RF_ISSUE/RF_DRAIN is ignored; no `mem_wen`.
  - `mem_rdata_valid` outside WB_WAIT is ignored.
- Reset values:
  - All outputs 0 except `fetch_gnt`=1.
  - State IDLE; all indices, latches and counters 0.
- Reset mid-operation aborts the operation. `fetch_done` is not produced for the aborted command.

## Timing
- Command handshake at cycle T gives the first `ext_req` or `mem_ren` at T+1.
- Refill: `ext_gnt` held high and response latency L (grant to valid) gives:
  - issue in T+1..T+list_width
  - last `mem_wen` at T+list_width+L
  - `fetch_done` at T+list_width+L+1
- Write-back: with `mem_rready`=1, mem read latency M and `ext_gnt`=1, each word takes M+2 cycles. `fetch_done` lands one cycle after the last grant.
- No-op: `fetch_done` at T+1, `fetch_gnt` high again at T+2.
- `fetch_gnt` is low from T+1 until the cycle after `fetch_done`. The earliest next handshake is the cycle after `fetch_done`.
- `ext_req` is held with stable address and data until `ext_gnt`.
- `mem_ren` is held with stable address until `mem_rready`.

## Configuration
- `LINE_FETCH_STAT_EN` defined:
  - `stat_refill_cnt` increments on each refill DONE.
  - `stat_wb_cnt` increments on each write-back DONE.
  - Both are 16-bit, saturating at 16'hFFFF. No-ops are not counted.
- Undefined: both counter outputs are tied to 0 and no counter flops exist.

## Test plan
- Refill: tag 2, addr 0x1000, `ext_gnt`=1, L=2, word data = index → `ext_addr` 0x1000..0x107C; `mem_waddr` {2,0}..{2,31} with data 0..31; `fetch_done` at T+35.
- Write-back: tag 1, addr 0x2000, M=1, memory preloaded 0xA0+i → 32 ext writes to 0x2000+4i with data 0xA0+i; `mem_ren` never overlaps `ext_req`; `fetch_done` one cycle after the 32nd grant.
- Backpressure: random `ext_gnt`/`mem_rready` at 30% → `ext_addr`, `ext_wdata` and `mem_raddr` stable while stalled; same final data as unthrottled.
- No-op: cmd 2'b10 → `fetch_done` at T+1; `ext_req`, `mem_wen` and `mem_ren` stay 0.
- Reset after 10 refill responses → all outputs at reset values; a following refill of tag 3 writes only {3,*}; stray responses in IDLE produce no `mem_wen`.
- With `LINE_FETCH_STAT_EN`: 2 refills, 1 write-back and 1 no-op → counts 2 and 1; without it → both counters read 0.
